// File: rtl/bcd_encoder.sv
// Sequential binary-to-BCD converter (double dabble, one bit per cycle) with valid/ready handshakes.
// Optional feature macro BCD_ENCODER_OVERFLOW_EN: adds o_overflow and saturates out-of-range results to all nines.
module bcd_encoder #(
  parameter int N = 3,
  localparam int W = 3 * N + (N + 2) / 3
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic [W-1:0]   i_bin,
  input  logic           i_valid,
  output logic           o_ready,
  output logic [4*N-1:0] o_bcd,
  output logic           o_valid,
  input  logic           i_ready
`ifdef BCD_ENCODER_OVERFLOW_EN
  ,
  output logic           o_overflow
`endif
);

  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(W);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } state_t;

  // One double-dabble step: adjust digits >= 5, then shift {scratch, binary} left by one.
  function automatic logic [4*N+W-1:0] dd_step(input logic [4*N-1:0] scr, input logic [W-1:0] bin);
    logic [4*N-1:0] adj;
    adj = scr;
    for (int k = 0; k < N; k++) begin
      if (adj[4*k +: 4] >= 4'd5) begin
        adj[4*k +: 4] = adj[4*k +: 4] + 4'd3;
      end else begin
        adj[4*k +: 4] = adj[4*k +: 4];
      end
    end
    return {adj[4*N-2:0], bin, 1'b0};
  endfunction

`ifdef BCD_ENCODER_OVERFLOW_EN
  localparam int WP = W + 1;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) begin
      p = p * 64'd10;
    end
    return p;
  endfunction

  function automatic logic [4*N-1:0] all_nines();
    logic [4*N-1:0] v;
    v = '0;
    for (int k = 0; k < N; k++) begin
      v[4*k +: 4] = 4'd9;
    end
    return v;
  endfunction

  localparam logic [W:0]     MAX_VAL = WP'(pow10(N) - 64'd1);
  localparam logic [4*N-1:0] NINES   = all_nines();
`endif

  state_t            state_r;
  state_t            state_nxt_s;
  logic [CW-1:0]     cnt_r;
  logic [W-1:0]      shreg_r;
  logic [4*N-1:0]    scratch_r;
  logic [4*N-1:0]    bcd_r;
  logic              ready_r;
  logic              valid_r;
  logic              accept_s;
  logic              last_step_s;
  logic [4*N+W-1:0]  step_s;
  logic [4*N-1:0]    step_scr_s;
  logic [W-1:0]      step_sh_s;
  logic [4*N-1:0]    final_s;

  assign step_s     = dd_step(scratch_r, shreg_r);
  assign step_scr_s = step_s[4*N+W-1 -: 4*N];
  assign step_sh_s  = step_s[W-1:0];

`ifdef BCD_ENCODER_OVERFLOW_EN
  logic ovf_r;
  logic ovf_out_r;

  assign final_s    = ovf_r ? NINES : step_scr_s;
  assign o_overflow = ovf_out_r;

  // Range check captured at acceptance, published alongside the result.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ovf_r     <= 1'b0;
      ovf_out_r <= 1'b0;
    end else if (accept_s) begin
      ovf_r     <= ({1'b0, i_bin} > MAX_VAL);
    end else if (last_step_s) begin
      ovf_out_r <= ovf_r;
    end
  end
`else
  assign final_s = step_scr_s;
`endif

  // Next-state decode and handshake qualifiers.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    last_step_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (i_valid) begin
          accept_s    = 1'b1;
          state_nxt_s = CONVERT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      CONVERT: begin
        if (cnt_r == CNT_ONE) begin
          last_step_s = 1'b1;
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = CONVERT;
        end
      end
      DONE: begin
        if (i_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State register; ready/valid are registered from the next state so they track it exactly.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r <= IDLE;
      ready_r <= 1'b1;
      valid_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      ready_r <= (state_nxt_s == IDLE);
      valid_r <= (state_nxt_s == DONE);
    end
  end

  // Conversion datapath; the result register only changes on the final step, so it holds between jobs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      scratch_r <= '0;
      shreg_r   <= '0;
      cnt_r     <= '0;
      bcd_r     <= '0;
    end else if (accept_s) begin
      scratch_r <= '0;
      shreg_r   <= i_bin;
      cnt_r     <= CNT_LOAD;
    end else if (state_r == CONVERT) begin
      scratch_r <= step_scr_s;
      shreg_r   <= step_sh_s;
      cnt_r     <= cnt_r - CNT_ONE;
      if (last_step_s) begin
        bcd_r <= final_s;
      end
    end
  end

  assign o_ready = ready_r;
  assign o_valid = valid_r;
  assign o_bcd   = bcd_r;

endmodule
